// File: rtl/dport_mux_pkg.sv
// dport_mux_pkg
// Shared definitions for the data-port multiplexer: default TCM window,
// response tag width, target encoding, the bundled response record, and
// the "is a request present" helper used by the router.
// Optional build macro used by this slice: DPORT_MUX_RESP_REG_EN.

package dport_mux_pkg;

  localparam int unsigned TAG_W            = 11;
  localparam logic [31:0] TCM_MEM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] TCM_MEM_MASK_DEF = 32'hFFFF_0000;

  typedef enum logic {
    TGT_EXT = 1'b0,
    TGT_TCM = 1'b1
  } tgt_e;

  typedef struct packed {
    logic [31:0]      data;
    logic             ack;
    logic             error;
    logic [TAG_W-1:0] tag;
  } resp_t;

  // Any operation bit set means the LSU is presenting a request this cycle.
  function automatic logic req_present(input logic       rd,
                                       input logic [3:0] wr,
                                       input logic       inv,
                                       input logic       wb,
                                       input logic       flush);
    return rd | (|wr) | inv | wb | flush;
  endfunction

endpackage

// File: rtl/dport_mux_resp.sv
// dport_mux_resp
// Response return path of the data-port multiplexer. Picks the TCM response
// whenever the TCM acks, the external port otherwise, and either passes it
// straight through or registers it for one cycle.
// Build macro: DPORT_MUX_RESP_REG_EN (defined = registered, +1 cycle).
// Ports:
//   clk            clock (registered build only)
//   rst_n          async active-low reset
//   tcm_resp_i     response bundle from the TCM port
//   ext_resp_i     response bundle from the external port
//   mem_data_rd_o  read data to the LSU
//   mem_ack_o      response strobe to the LSU
//   mem_error_o    response error to the LSU
//   mem_resp_tag_o response tag to the LSU

module dport_mux_resp
  import dport_mux_pkg::*;
(
`ifdef DPORT_MUX_RESP_REG_EN
  input  logic             clk,
`endif
  input  logic             rst_n,
  input  resp_t            tcm_resp_i,
  input  resp_t            ext_resp_i,
  output logic [31:0]      mem_data_rd_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [TAG_W-1:0] mem_resp_tag_o
);

  resp_t sel_resp;

  always_comb begin
    sel_resp = tcm_resp_i.ack ? tcm_resp_i : ext_resp_i;
  end

`ifdef DPORT_MUX_RESP_REG_EN
  resp_t resp_q;

  // Captured every cycle; reset clears ack/error so nothing seen during
  // reset is ever delivered afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q <= sel_resp;
    end
  end

  assign mem_data_rd_o  = resp_q.data;
  assign mem_ack_o      = resp_q.ack;
  assign mem_error_o    = resp_q.error;
  assign mem_resp_tag_o = resp_q.tag;
`else
  // Strobes are forced low while reset is held so stray responses are dropped.
  assign mem_data_rd_o  = sel_resp.data;
  assign mem_ack_o      = sel_resp.ack & rst_n;
  assign mem_error_o    = sel_resp.error & rst_n;
  assign mem_resp_tag_o = sel_resp.tag;
`endif

endmodule

// File: rtl/dport_mux.sv
// dport_mux
// Routes LSU data-port requests to the TCM or the external (AXI bridge) port
// by address, keeps responses in order by stalling a switch of target while
// requests are outstanding, and merges the two response streams.
// Build macro: DPORT_MUX_RESP_REG_EN (registered response path, +1 cycle).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mem_*_i / mem_*_o   LSU request in, LSU response out
//   mem_tcm_*_o / _i    TCM request out, TCM response in
//   mem_ext_*_o / _i    external request out, external response in

module dport_mux
  import dport_mux_pkg::*;
#(
  parameter logic [31:0] TCM_MEM_BASE = TCM_MEM_BASE_DEF,
  parameter logic [31:0] TCM_MEM_MASK = TCM_MEM_MASK_DEF,
  parameter int unsigned PEND_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // LSU request
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic             mem_cacheable_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  input  logic             mem_invalidate_i,
  input  logic             mem_writeback_i,
  input  logic             mem_flush_i,
  // LSU response
  output logic [31:0]      mem_data_rd_o,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [TAG_W-1:0] mem_resp_tag_o,
  // TCM request
  output logic [31:0]      mem_tcm_addr_o,
  output logic [31:0]      mem_tcm_data_wr_o,
  output logic             mem_tcm_rd_o,
  output logic [3:0]       mem_tcm_wr_o,
  output logic             mem_tcm_cacheable_o,
  output logic [TAG_W-1:0] mem_tcm_req_tag_o,
  output logic             mem_tcm_invalidate_o,
  output logic             mem_tcm_writeback_o,
  output logic             mem_tcm_flush_o,
  // TCM response
  input  logic [31:0]      mem_tcm_data_rd_i,
  input  logic             mem_tcm_accept_i,
  input  logic             mem_tcm_ack_i,
  input  logic             mem_tcm_error_i,
  input  logic [TAG_W-1:0] mem_tcm_resp_tag_i,
  // External request
  output logic [31:0]      mem_ext_addr_o,
  output logic [31:0]      mem_ext_data_wr_o,
  output logic             mem_ext_rd_o,
  output logic [3:0]       mem_ext_wr_o,
  output logic             mem_ext_cacheable_o,
  output logic [TAG_W-1:0] mem_ext_req_tag_o,
  output logic             mem_ext_invalidate_o,
  output logic             mem_ext_writeback_o,
  output logic             mem_ext_flush_o,
  // External response
  input  logic [31:0]      mem_ext_data_rd_i,
  input  logic             mem_ext_accept_i,
  input  logic             mem_ext_ack_i,
  input  logic             mem_ext_error_i,
  input  logic [TAG_W-1:0] mem_ext_resp_tag_i
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q;
  tgt_e              tgt_q;
  tgt_e              sel_tgt;
  logic              present;
  logic              stall;
  logic              go_tcm;
  logic              go_ext;
  logic              accepted;

  assign present = req_present(mem_rd_i, mem_wr_i, mem_invalidate_i,
                               mem_writeback_i, mem_flush_i);
  assign sel_tgt = ((mem_addr_i & TCM_MEM_MASK) == TCM_MEM_BASE) ? TGT_TCM : TGT_EXT;

  // Switching target with requests in flight could let the faster port answer
  // first, so hold off until the old target has drained. A full counter also
  // stalls so it can never wrap.
  assign stall = ((pend_q != '0) && (sel_tgt != tgt_q)) || (pend_q == PEND_MAX);

  assign go_tcm = (sel_tgt == TGT_TCM) && !stall;
  assign go_ext = (sel_tgt == TGT_EXT) && !stall;

  assign mem_accept_o = !stall && ((sel_tgt == TGT_TCM) ? mem_tcm_accept_i : mem_ext_accept_i);
  assign accepted     = present && mem_accept_o;

  assign mem_tcm_addr_o       = mem_addr_i;
  assign mem_tcm_data_wr_o    = mem_data_wr_i;
  assign mem_tcm_cacheable_o  = mem_cacheable_i;
  assign mem_tcm_req_tag_o    = mem_req_tag_i;
  assign mem_tcm_rd_o         = mem_rd_i & go_tcm;
  assign mem_tcm_wr_o         = mem_wr_i & {4{go_tcm}};
  assign mem_tcm_invalidate_o = mem_invalidate_i & go_tcm;
  assign mem_tcm_writeback_o  = mem_writeback_i & go_tcm;
  assign mem_tcm_flush_o      = mem_flush_i & go_tcm;

  assign mem_ext_addr_o       = mem_addr_i;
  assign mem_ext_data_wr_o    = mem_data_wr_i;
  assign mem_ext_cacheable_o  = mem_cacheable_i;
  assign mem_ext_req_tag_o    = mem_req_tag_i;
  assign mem_ext_rd_o         = mem_rd_i & go_ext;
  assign mem_ext_wr_o         = mem_wr_i & {4{go_ext}};
  assign mem_ext_invalidate_o = mem_invalidate_i & go_ext;
  assign mem_ext_writeback_o  = mem_writeback_i & go_ext;
  assign mem_ext_flush_o      = mem_flush_i & go_ext;

  // Outstanding count tracks the ack actually delivered upstream, so the
  // registered build naturally keeps one extra cycle of occupancy. An ack
  // with nothing outstanding is passed through but never underflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      tgt_q  <= TGT_EXT;
    end else begin
      if (accepted) begin
        tgt_q <= sel_tgt;
      end
      case ({accepted, mem_ack_o})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   if (pend_q != '0) pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  resp_t tcm_resp;
  resp_t ext_resp;

  assign tcm_resp = '{data: mem_tcm_data_rd_i, ack: mem_tcm_ack_i,
                      error: mem_tcm_error_i, tag: mem_tcm_resp_tag_i};
  assign ext_resp = '{data: mem_ext_data_rd_i, ack: mem_ext_ack_i,
                      error: mem_ext_error_i, tag: mem_ext_resp_tag_i};

  dport_mux_resp u_resp (
`ifdef DPORT_MUX_RESP_REG_EN
    .clk            (clk),
`endif
    .rst_n          (rst_n),
    .tcm_resp_i     (tcm_resp),
    .ext_resp_i     (ext_resp),
    .mem_data_rd_o  (mem_data_rd_o),
    .mem_ack_o      (mem_ack_o),
    .mem_error_o    (mem_error_o),
    .mem_resp_tag_o (mem_resp_tag_o)
  );

  a_no_dual_ack: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_tcm_ack_i && mem_ext_ack_i));

  a_no_ack_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    mem_ack_o |-> (pend_q != '0));

endmodule

// File: tb/tb_dport_mux.sv
// tb_dport_mux
// Self-checking bench for dport_mux: directed scenarios followed by a
// randomized run against a queue-based ordering model.
// Build macro: DPORT_MUX_RESP_REG_EN selects the expected response latency.

module tb_dport_mux;

`ifdef DPORT_MUX_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int PEND_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr_i, mem_data_wr_i;
  logic        mem_rd_i, mem_cacheable_i, mem_invalidate_i, mem_writeback_i, mem_flush_i;
  logic [3:0]  mem_wr_i;
  logic [10:0] mem_req_tag_i;
  logic [31:0] mem_data_rd_o;
  logic        mem_accept_o, mem_ack_o, mem_error_o;
  logic [10:0] mem_resp_tag_o;
  logic [31:0] mem_tcm_addr_o, mem_tcm_data_wr_o, mem_ext_addr_o, mem_ext_data_wr_o;
  logic        mem_tcm_rd_o, mem_tcm_cacheable_o, mem_tcm_invalidate_o, mem_tcm_writeback_o, mem_tcm_flush_o;
  logic        mem_ext_rd_o, mem_ext_cacheable_o, mem_ext_invalidate_o, mem_ext_writeback_o, mem_ext_flush_o;
  logic [3:0]  mem_tcm_wr_o, mem_ext_wr_o;
  logic [10:0] mem_tcm_req_tag_o, mem_ext_req_tag_o;
  logic [31:0] mem_tcm_data_rd_i, mem_ext_data_rd_i;
  logic        mem_tcm_accept_i, mem_tcm_ack_i, mem_tcm_error_i;
  logic        mem_ext_accept_i, mem_ext_ack_i, mem_ext_error_i;
  logic [10:0] mem_tcm_resp_tag_i, mem_ext_resp_tag_i;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dport_mux dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_cacheable_i(mem_cacheable_i), .mem_req_tag_i(mem_req_tag_i),
    .mem_invalidate_i(mem_invalidate_i), .mem_writeback_i(mem_writeback_i), .mem_flush_i(mem_flush_i),
    .mem_data_rd_o(mem_data_rd_o), .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
    .mem_error_o(mem_error_o), .mem_resp_tag_o(mem_resp_tag_o),
    .mem_tcm_addr_o(mem_tcm_addr_o), .mem_tcm_data_wr_o(mem_tcm_data_wr_o), .mem_tcm_rd_o(mem_tcm_rd_o),
    .mem_tcm_wr_o(mem_tcm_wr_o), .mem_tcm_cacheable_o(mem_tcm_cacheable_o), .mem_tcm_req_tag_o(mem_tcm_req_tag_o),
    .mem_tcm_invalidate_o(mem_tcm_invalidate_o), .mem_tcm_writeback_o(mem_tcm_writeback_o),
    .mem_tcm_flush_o(mem_tcm_flush_o),
    .mem_tcm_data_rd_i(mem_tcm_data_rd_i), .mem_tcm_accept_i(mem_tcm_accept_i), .mem_tcm_ack_i(mem_tcm_ack_i),
    .mem_tcm_error_i(mem_tcm_error_i), .mem_tcm_resp_tag_i(mem_tcm_resp_tag_i),
    .mem_ext_addr_o(mem_ext_addr_o), .mem_ext_data_wr_o(mem_ext_data_wr_o), .mem_ext_rd_o(mem_ext_rd_o),
    .mem_ext_wr_o(mem_ext_wr_o), .mem_ext_cacheable_o(mem_ext_cacheable_o), .mem_ext_req_tag_o(mem_ext_req_tag_o),
    .mem_ext_invalidate_o(mem_ext_invalidate_o), .mem_ext_writeback_o(mem_ext_writeback_o),
    .mem_ext_flush_o(mem_ext_flush_o),
    .mem_ext_data_rd_i(mem_ext_data_rd_i), .mem_ext_accept_i(mem_ext_accept_i), .mem_ext_ack_i(mem_ext_ack_i),
    .mem_ext_error_i(mem_ext_error_i), .mem_ext_resp_tag_i(mem_ext_resp_tag_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_addr_i = '0; mem_data_wr_i = '0; mem_rd_i = 1'b0; mem_wr_i = '0;
    mem_cacheable_i = 1'b0; mem_req_tag_i = '0;
    mem_invalidate_i = 1'b0; mem_writeback_i = 1'b0; mem_flush_i = 1'b0;
    mem_tcm_data_rd_i = '0; mem_tcm_accept_i = 1'b1; mem_tcm_ack_i = 1'b0;
    mem_tcm_error_i = 1'b0; mem_tcm_resp_tag_i = '0;
    mem_ext_data_rd_i = '0; mem_ext_accept_i = 1'b1; mem_ext_ack_i = 1'b0;
    mem_ext_error_i = 1'b0; mem_ext_resp_tag_i = '0;
  endtask

  // One memory-side ack now, then wait until it has reached the LSU and the
  // following edge has retired it from the outstanding count.
  task automatic mem_ack_and_wait(input bit is_tcm);
    mem_tcm_ack_i = is_tcm;
    mem_ext_ack_i = !is_tcm;
    step();
    mem_tcm_ack_i = 1'b0;
    mem_ext_ack_i = 1'b0;
    repeat (LAT) step();
    #3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_tcm_ack_i = 1'b1;
    mem_tcm_error_i = 1'b1;
    #2;
    checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL rst_ack: got %b want 0", mem_ack_o); else passed++;
    checks++; if (mem_error_o !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", mem_error_o); else passed++;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL rst_pend: got %0d want 0", dut.pend_q); else passed++;
    checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL rst_ack_hold: got %b want 0", mem_ack_o); else passed++;
    mem_tcm_ack_i = 1'b0;
    mem_tcm_error_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tcm_read();
    step();
    mem_addr_i = 32'h0000_0100; mem_rd_i = 1'b1;
    #3;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL tcm_rd_accept: got %b want 1", mem_accept_o); else passed++;
    checks++; if (mem_tcm_rd_o !== 1'b1) $display("[TB] FAIL tcm_rd_strobe: got %b want 1", mem_tcm_rd_o); else passed++;
    checks++; if (mem_ext_rd_o !== 1'b0) $display("[TB] FAIL tcm_rd_ext_quiet: got %b want 0", mem_ext_rd_o); else passed++;
    step();
    mem_rd_i = 1'b0;
    #3;
    checks++; if (dut.pend_q !== 4'd1) $display("[TB] FAIL tcm_rd_pend1: got %0d want 1", dut.pend_q); else passed++;
    step();
    mem_tcm_ack_i = 1'b1; mem_tcm_data_rd_i = 32'hDEAD_BEEF; mem_ext_data_rd_i = 32'h1234_5678;
    #3;
    for (int c = 0; c < LAT; c++) begin
      checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL tcm_rd_early_ack: got %b want 0", mem_ack_o); else passed++;
      step();
      mem_tcm_ack_i = 1'b0; mem_tcm_data_rd_i = '0;
      #3;
    end
    checks++; if (mem_ack_o !== 1'b1) $display("[TB] FAIL tcm_rd_ack: got %b want 1", mem_ack_o); else passed++;
    checks++; if (mem_data_rd_o !== 32'hDEAD_BEEF) $display("[TB] FAIL tcm_rd_data: got %h want deadbeef", mem_data_rd_o); else passed++;
    checks++; if (mem_ext_rd_o !== 1'b0) $display("[TB] FAIL tcm_rd_ext_never: got %b want 0", mem_ext_rd_o); else passed++;
    step();
    mem_tcm_ack_i = 1'b0; mem_tcm_data_rd_i = '0; mem_ext_data_rd_i = '0;
    #3;
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL tcm_rd_pend0: got %0d want 0", dut.pend_q); else passed++;
  endtask

  task automatic test_ext_write();
    step();
    mem_addr_i = 32'h8000_0000; mem_wr_i = 4'hF; mem_data_wr_i = 32'hA5A5_0F0F;
    #3;
    checks++; if (mem_ext_wr_o !== 4'hF) $display("[TB] FAIL ext_wr_strobe: got %h want f", mem_ext_wr_o); else passed++;
    checks++; if (mem_tcm_wr_o !== 4'h0) $display("[TB] FAIL ext_wr_tcm_quiet: got %h want 0", mem_tcm_wr_o); else passed++;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL ext_wr_accept: got %b want 1", mem_accept_o); else passed++;
    checks++; if (mem_ext_data_wr_o !== 32'hA5A5_0F0F) $display("[TB] FAIL ext_wr_data: got %h want a5a50f0f", mem_ext_data_wr_o); else passed++;
    step();
    mem_wr_i = 4'h0;
    #3;
    checks++; if (dut.pend_q !== 4'd1) $display("[TB] FAIL ext_wr_pend1: got %0d want 1", dut.pend_q); else passed++;
    mem_ack_and_wait(1'b0);
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL ext_wr_pend0: got %0d want 0", dut.pend_q); else passed++;
  endtask

  task automatic test_order_stall();
    step();
    mem_addr_i = 32'h0000_0040; mem_rd_i = 1'b1;
    #3;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL ord_first_accept: got %b want 1", mem_accept_o); else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      mem_addr_i = 32'h8000_0004;
      #3;
      checks++; if (mem_accept_o !== 1'b0) $display("[TB] FAIL ord_stall_accept: got %b want 0", mem_accept_o); else passed++;
      checks++; if (mem_ext_rd_o !== 1'b0) $display("[TB] FAIL ord_stall_extrd: got %b want 0", mem_ext_rd_o); else passed++;
    end
    step();
    mem_tcm_ack_i = 1'b1;
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c > 0) begin
        step();
        mem_tcm_ack_i = 1'b0;
      end
      #3;
      checks++; if (mem_accept_o !== (c == LAT + 1)) $display("[TB] FAIL ord_release_accept c=%0d: got %b want %b", c, mem_accept_o, (c == LAT + 1)); else passed++;
      checks++; if (mem_ext_rd_o !== (c == LAT + 1)) $display("[TB] FAIL ord_release_extrd c=%0d: got %b want %b", c, mem_ext_rd_o, (c == LAT + 1)); else passed++;
    end
    step();
    mem_rd_i = 1'b0;
    mem_ack_and_wait(1'b0);
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL ord_pend0: got %0d want 0", dut.pend_q); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < PEND_MAX; i++) begin
      step();
      mem_addr_i = 32'h0000_0200 + 32'(i * 4); mem_rd_i = 1'b1;
      #3;
      checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL sat_fill_accept i=%0d: got %b want 1", i, mem_accept_o); else passed++;
    end
    step();
    #3;
    checks++; if (mem_accept_o !== 1'b0) $display("[TB] FAIL sat_16th_accept: got %b want 0", mem_accept_o); else passed++;
    checks++; if (mem_tcm_rd_o !== 1'b0) $display("[TB] FAIL sat_16th_tcmrd: got %b want 0", mem_tcm_rd_o); else passed++;
    checks++; if (dut.pend_q !== 4'd15) $display("[TB] FAIL sat_pend15: got %0d want 15", dut.pend_q); else passed++;
    step();
    mem_tcm_ack_i = 1'b1;
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c > 0) begin
        step();
        mem_tcm_ack_i = 1'b0;
      end
      #3;
      checks++; if (mem_accept_o !== (c == LAT + 1)) $display("[TB] FAIL sat_release_accept c=%0d: got %b want %b", c, mem_accept_o, (c == LAT + 1)); else passed++;
    end
    step();
    mem_rd_i = 1'b0;
    #3;
    checks++; if (dut.pend_q !== 4'd15) $display("[TB] FAIL sat_refill_pend: got %0d want 15", dut.pend_q); else passed++;
    mem_tcm_ack_i = 1'b1;
    repeat (PEND_MAX - 1) step();
    step();
    mem_tcm_ack_i = 1'b0;
    repeat (LAT) step();
    #3;
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL sat_drain_pend: got %0d want 0", dut.pend_q); else passed++;
  endtask

  task automatic test_same_cycle();
    step();
    mem_addr_i = 32'h8000_0010; mem_rd_i = 1'b1;
    #3;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL same_first_accept: got %b want 1", mem_accept_o); else passed++;
    step();
    mem_rd_i = 1'b0;
    mem_ext_ack_i = 1'b1; mem_ext_resp_tag_i = 11'h7A5; mem_ext_error_i = 1'b1; mem_ext_data_rd_i = 32'h0BAD_F00D;
    for (int c = 0; c <= LAT; c++) begin
      if (c > 0) begin
        step();
        mem_ext_ack_i = 1'b0; mem_ext_resp_tag_i = '0; mem_ext_error_i = 1'b0; mem_ext_data_rd_i = '0;
      end
      if (c == LAT) begin
        mem_addr_i = 32'h8000_0020; mem_rd_i = 1'b1;
      end
      #3;
    end
    checks++; if (mem_ack_o !== 1'b1) $display("[TB] FAIL same_ack: got %b want 1", mem_ack_o); else passed++;
    checks++; if (mem_resp_tag_o !== 11'h7A5) $display("[TB] FAIL same_tag: got %h want 7a5", mem_resp_tag_o); else passed++;
    checks++; if (mem_error_o !== 1'b1) $display("[TB] FAIL same_err: got %b want 1", mem_error_o); else passed++;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL same_accept: got %b want 1", mem_accept_o); else passed++;
    step();
    mem_rd_i = 1'b0;
    #3;
    checks++; if (dut.pend_q !== 4'd1) $display("[TB] FAIL same_pend: got %0d want 1", dut.pend_q); else passed++;
    mem_ack_and_wait(1'b0);
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL same_pend0: got %0d want 0", dut.pend_q); else passed++;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      step();
      mem_addr_i = 32'h0000_0300; mem_rd_i = 1'b1;
      #3;
      checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL mrst_fill_accept: got %b want 1", mem_accept_o); else passed++;
    end
    step();
    mem_rd_i = 1'b0;
    #3;
    checks++; if (dut.pend_q !== 4'd3) $display("[TB] FAIL mrst_pend3: got %0d want 3", dut.pend_q); else passed++;
    mem_tcm_ack_i = 1'b1; mem_tcm_error_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL mrst_pend0: got %0d want 0", dut.pend_q); else passed++;
    checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL mrst_ack: got %b want 0", mem_ack_o); else passed++;
    checks++; if (mem_error_o !== 1'b0) $display("[TB] FAIL mrst_err: got %b want 0", mem_error_o); else passed++;
    step();
    #3;
    checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL mrst_ack_hold: got %b want 0", mem_ack_o); else passed++;
    mem_tcm_ack_i = 1'b0; mem_tcm_error_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mem_addr_i = 32'h9000_0000; mem_rd_i = 1'b1;
    #3;
    checks++; if (mem_accept_o !== 1'b1) $display("[TB] FAIL mrst_ext_accept: got %b want 1", mem_accept_o); else passed++;
    checks++; if (mem_ext_rd_o !== 1'b1) $display("[TB] FAIL mrst_ext_rd: got %b want 1", mem_ext_rd_o); else passed++;
    checks++; if (mem_ack_o !== 1'b0) $display("[TB] FAIL mrst_no_stale_ack: got %b want 0", mem_ack_o); else passed++;
    step();
    mem_rd_i = 1'b0;
    #3;
    checks++; if (dut.pend_q !== 4'd1) $display("[TB] FAIL mrst_pend1: got %0d want 1", dut.pend_q); else passed++;
    mem_ack_and_wait(1'b0);
  endtask

  // Model: up_q lists the target of every request the LSU still awaits, in
  // issue order; mem_q is what the memories have yet to answer. A new request
  // must wait if it would join a queue of a different target or a full one.
  task automatic test_random();
    int          up_q[$];
    int          mem_q[$];
    logic [44:0] pipe[$];
    logic [44:0] cur, exp_r, got_r;
    bit          sel, stall, present, exp_acc, exp_go;
    idle_inputs();
    step();
    repeat (LAT) pipe.push_back('0);
    for (int n = 0; n < 460; n++) begin
      step();
      mem_tcm_ack_i = 1'b0; mem_ext_ack_i = 1'b0;
      mem_tcm_data_rd_i = $urandom; mem_ext_data_rd_i = $urandom;
      mem_tcm_resp_tag_i = 11'($urandom); mem_ext_resp_tag_i = 11'($urandom);
      mem_tcm_error_i = 1'($urandom); mem_ext_error_i = 1'($urandom);
      if (mem_q.size() > 0 && (n >= 400 || $urandom_range(2) == 0)) begin
        if (mem_q.pop_front() == 1) mem_tcm_ack_i = 1'b1;
        else mem_ext_ack_i = 1'b1;
      end
      mem_rd_i = 1'b0; mem_wr_i = '0; mem_invalidate_i = 1'b0; mem_writeback_i = 1'b0; mem_flush_i = 1'b0;
      present = (n < 400) && ($urandom_range(9) < 6);
      if (present) begin
        case ($urandom_range(4))
          0: mem_rd_i = 1'b1;
          1: mem_wr_i = 4'($urandom_range(15, 1));
          2: mem_invalidate_i = 1'b1;
          3: mem_writeback_i = 1'b1;
          default: mem_flush_i = 1'b1;
        endcase
      end
      mem_addr_i = ($urandom_range(1) == 0) ? {16'h0000, 16'($urandom)} : {1'b1, 31'($urandom)};
      mem_data_wr_i = $urandom; mem_req_tag_i = 11'($urandom);
      mem_tcm_accept_i = ($urandom_range(3) != 0);
      mem_ext_accept_i = ($urandom_range(3) != 0);
      sel = (mem_addr_i[31:16] == 16'h0000);
      stall = (up_q.size() != 0 && up_q[$] != int'(sel)) || (up_q.size() == PEND_MAX);
      exp_acc = !stall && (sel ? mem_tcm_accept_i : mem_ext_accept_i);
      exp_go = !stall;
      cur = mem_tcm_ack_i ? {1'b1, mem_tcm_error_i, mem_tcm_resp_tag_i, mem_tcm_data_rd_i}
                          : {mem_ext_ack_i, mem_ext_error_i, mem_ext_resp_tag_i, mem_ext_data_rd_i};
      pipe.push_back(cur);
      exp_r = pipe.pop_front();
      #3;
      got_r = {mem_ack_o, mem_error_o, mem_resp_tag_o, mem_data_rd_o};
      checks++; if (mem_accept_o !== exp_acc) $display("[TB] FAIL rnd_accept n=%0d: got %b want %b", n, mem_accept_o, exp_acc); else passed++;
      checks++; if (mem_tcm_rd_o !== (mem_rd_i & sel & exp_go)) $display("[TB] FAIL rnd_tcm_rd n=%0d: got %b want %b", n, mem_tcm_rd_o, mem_rd_i & sel & exp_go); else passed++;
      checks++; if (mem_ext_rd_o !== (mem_rd_i & !sel & exp_go)) $display("[TB] FAIL rnd_ext_rd n=%0d: got %b want %b", n, mem_ext_rd_o, mem_rd_i & !sel & exp_go); else passed++;
      checks++; if (mem_tcm_wr_o !== ((sel && exp_go) ? mem_wr_i : 4'h0)) $display("[TB] FAIL rnd_tcm_wr n=%0d: got %h", n, mem_tcm_wr_o); else passed++;
      checks++; if (mem_ext_wr_o !== ((!sel && exp_go) ? mem_wr_i : 4'h0)) $display("[TB] FAIL rnd_ext_wr n=%0d: got %h", n, mem_ext_wr_o); else passed++;
      checks++; if ({mem_tcm_invalidate_o, mem_tcm_writeback_o, mem_tcm_flush_o} !== ((sel && exp_go) ? {mem_invalidate_i, mem_writeback_i, mem_flush_i} : 3'b000)) $display("[TB] FAIL rnd_tcm_maint n=%0d", n); else passed++;
      checks++; if ({mem_ext_invalidate_o, mem_ext_writeback_o, mem_ext_flush_o} !== ((!sel && exp_go) ? {mem_invalidate_i, mem_writeback_i, mem_flush_i} : 3'b000)) $display("[TB] FAIL rnd_ext_maint n=%0d", n); else passed++;
      checks++; if (got_r !== exp_r) $display("[TB] FAIL rnd_resp n=%0d: got %h want %h", n, got_r, exp_r); else passed++;
      checks++; if (int'(dut.pend_q) != up_q.size()) $display("[TB] FAIL rnd_pend n=%0d: got %0d want %0d", n, dut.pend_q, up_q.size()); else passed++;
      if (exp_r[44] && up_q.size() != 0) void'(up_q.pop_front());
      if (present && exp_acc) begin
        up_q.push_back(int'(sel));
        mem_q.push_back(int'(sel));
      end
    end
    step();
    idle_inputs();
    #3;
    checks++; if (dut.pend_q !== 4'd0) $display("[TB] FAIL rnd_final_pend: got %0d want 0", dut.pend_q); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_tcm_read();
    test_ext_write();
    test_order_stall();
    test_saturation();
    test_same_cycle();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dport_mux.md
DPORT_MUX -- requirements
Module: dport_mux

Interface
REQ-001 SHALL have parameter TCM_MEM_BASE, default 32'h0000_0000, base address of the TCM window.
REQ-002 SHALL have parameter TCM_MEM_MASK, default 32'hFFFF_0000, address bits compared against TCM_MEM_BASE.
REQ-003 SHALL have parameter PEND_W, default 4, width of the outstanding-request counter.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i, mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i  in  32/32/1/4/1/11/1/1/1  LSU request.
REQ-007 mem_data_rd_o, mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o  out  32/1/1/1/11  LSU response.
REQ-008 mem_tcm_*_o, with the same nine request fields as REQ-006  out  same widths  TCM-side request.
REQ-009 mem_tcm_data_rd_i, mem_tcm_accept_i, mem_tcm_ack_i, mem_tcm_error_i, mem_tcm_resp_tag_i  in  32/1/1/1/11  TCM-side response.
REQ-010 mem_ext_*_o and mem_ext_*_i, with the same fields as REQ-008 and REQ-009  out/in  same widths  external (AXI bridge) side.

Function
REQ-011 A request SHALL be present when mem_rd_i, any bit of mem_wr_i, mem_invalidate_i, mem_writeback_i or mem_flush_i is set.
REQ-012 SHALL select the TCM when (mem_addr_i & TCM_MEM_MASK) == TCM_MEM_BASE, and the external port otherwise; the selection is combinational.
REQ-013 SHALL drive the request fields to both ports, with rd/wr/invalidate/writeback/flush gated to zero on the non-selected port and on any stalled cycle.
REQ-014 mem_accept_o SHALL equal the selected port's accept when not stalled, and 0 when stalled.
REQ-015 SHALL keep pend_q (PEND_W bits) and tgt_q (1=TCM); a request is accepted when it is present and mem_accept_o=1.
REQ-016 Accept only: pend_q+1 and tgt_q<=selected target. Upstream ack only: pend_q-1. Both in the same cycle: pend_q unchanged and tgt_q updated.
REQ-017 SHALL stall when pend_q!=0 and the selected target != tgt_q, so responses cannot reorder.
REQ-018 SHALL stall when pend_q == 2**PEND_W-1 (saturation); pend_q never wraps.
REQ-019 SHALL take mem_ack_o, mem_data_rd_o, mem_error_o and mem_resp_tag_o from the TCM port when mem_tcm_ack_i=1, and from the external port otherwise.
REQ-020 Simultaneous mem_tcm_ack_i and mem_ext_ack_i is illegal; a simulation assertion SHALL flag it.
REQ-021 An upstream ack while pend_q==0 SHALL be passed through, leaving pend_q at 0 (no underflow), and SHALL be flagged by an assertion.

Reset
REQ-022 On rst_n low: pend_q=0, tgt_q=0, response registers cleared; mem_ack_o=0 and mem_error_o=0 at once. Request outputs follow their inputs combinationally.
REQ-023 Responses arriving during reset SHALL be discarded; after release the block accepts on the first present request.

Configuration
REQ-024 With DPORT_MUX_RESP_REG_EN defined, the four response outputs SHALL be registered, giving +1 cycle of latency, and pend_q decrements on the registered mem_ack_o.
REQ-025 Without DPORT_MUX_RESP_REG_EN, the response path SHALL be purely combinational, with 0 cycles of added latency.

Structure
REQ-026 The shared package SHALL hold the default TCM base/mask constants and the 11-bit tag width.
REQ-027 The response select/register path SHALL be sub-module dport_mux_resp; request routing and counters stay in the top level.

Verification
REQ-028 Read of 0x0000_0100, TCM accept=1, ack 2 cycles later with data 0xDEADBEEF -> mem_data_rd_o=0xDEADBEEF; ext port never sees rd.
REQ-029 Write 0x8000_0000, wr=4'hF -> only mem_ext_wr_o=4'hF; TCM wr=0; pend_q 0->1->0 on ack.
REQ-030 Pending TCM read, then ext read issued -> mem_accept_o=0 until TCM ack; ext rd asserted only in the cycle after the ack.
REQ-031 Fifteen TCM reads with no acks (PEND_W=4) -> 16th stalled; one ack -> next accepted; pend_q never exceeds 15.
REQ-032 Accept and ack in the same cycle with pend_q=1 -> pend_q stays 1; ext ack with tag 0x7A5 and error=1 -> mem_resp_tag_o=0x7A5, mem_error_o=1.
REQ-033 rst_n asserted with pend_q=3 -> pend_q=0 and mem_ack_o=0 immediately; after release, an ext request to 0x9000_0000 is accepted without stall; repeat all cases with DPORT_MUX_RESP_REG_EN, expecting +1 cycle of latency.
